// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point encoder/decoder pair:
// default geometry, derived limits, FSM state type and rounding-mode codes.
package bfp_pkg;

    localparam int DEF_IN_W       = 32;
    localparam int DEF_SF_W       = 12;
    localparam int DEF_Q_W        = 12;
    localparam int DEF_OUT_W      = 32;
    localparam int DEF_BLOCK_SIZE = 1024;

    localparam int ROUND_TRUNC    = 0;
    localparam int ROUND_HALF_UP  = 1;

    typedef enum logic [1:0] {
        COLLECT,
        SCALE,
        EMIT_SF,
        EMIT_DATA
    } bfp_state_e;

    // Symmetric clamp limit: the most negative code is never produced
    function automatic int max_q(input int q_w);
        return (1 << (q_w - 1)) - 1;
    endfunction

    function automatic int max_sf(input int in_w, input int q_w);
        return in_w - q_w + 1;
    endfunction

endpackage

// File: rtl/bfp_exponent_calc.sv
// Leading-one detector on a block's peak magnitude, turned into the shared
// right-shift exponent e = max(0, bitlen(max_abs) - (Q_W-1)).
module bfp_exponent_calc
    import bfp_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int Q_W  = DEF_Q_W,
    parameter int SF_W = DEF_SF_W
) (
    input  logic [IN_W-1:0] max_abs,
    output logic [SF_W-1:0] exp_out
);

    localparam int LW = $clog2(IN_W + 1);
    localparam logic [LW-1:0] MANT_BITS = LW'(Q_W - 1);

    logic [IN_W-1:0] seen_above;
    logic [LW-1:0]   bit_len;

    // seen_above[i] is set when any bit at or above i is set, so its
    // population count is exactly the bit length of max_abs.
    genvar gi;
    generate
        for (gi = 0; gi < IN_W; gi++) begin : g_lod
            assign seen_above[gi] = |max_abs[IN_W-1:gi];
        end
    endgenerate

    always_comb begin
        bit_len = '0;
        for (int i = 0; i < IN_W; i++) begin
            bit_len = bit_len + LW'(seen_above[i]);
        end
        if (bit_len > MANT_BITS) begin
            exp_out = SF_W'(bit_len - MANT_BITS);
        end else begin
            exp_out = '0;
        end
    end

endmodule

// File: rtl/bfp_block_quantizer.sv
// Block-floating-point encoder: buffers BLOCK_SIZE samples, derives a shared
// exponent from the peak magnitude, then emits the scale word and quantized samples.
module bfp_block_quantizer
    import bfp_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int SF_W       = DEF_SF_W,
    parameter int Q_W        = DEF_Q_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int ROUND_MODE = ROUND_HALF_UP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_is_scale,
    output logic             out_last
);

    localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
    localparam logic signed [IN_W:0]  MAX_Q_EXT = (IN_W + 1)'(max_q(Q_W));
    localparam logic signed [Q_W-1:0] MAX_Q_Q   = Q_W'(max_q(Q_W));

    bfp_state_e       state_reg;
    logic [IDX_W-1:0] wr_idx_reg;
    logic [IDX_W-1:0] rd_idx_reg;
    logic [IDX_W-1:0] out_idx_reg;
    logic [IN_W-1:0]  max_abs_reg;
    logic [SF_W-1:0]  exp_reg;
    logic [SF_W-1:0]  exp_next;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [OUT_W-1:0] out_data_reg;
    logic             out_is_scale_reg;
    logic             out_last_reg;

    logic [IN_W-1:0]  sample_mem [BLOCK_SIZE];
    logic [IN_W-1:0]  rd_data_reg;

    logic             in_fire;
    logic             out_fire;
    logic             mem_re;
    logic [IN_W-1:0]  abs_in;

    logic signed [IN_W:0]    q_ext;
    logic signed [IN_W:0]    q_rnd;
    logic signed [IN_W:0]    q_shift;
    logic signed [Q_W-1:0]   q_sat;
    logic signed [OUT_W-1:0] q_word;

    assign in_fire  = in_valid && in_ready_reg;
    assign out_fire = out_valid_reg && out_ready;
    assign mem_re   = (state_reg == SCALE) || out_fire;
    // Unsigned on IN_W bits so the most negative input maps to 2^(IN_W-1)
    assign abs_in   = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign out_is_scale = out_is_scale_reg;
    assign out_last     = out_last_reg;

    bfp_exponent_calc #(
        .IN_W (IN_W),
        .Q_W  (Q_W),
        .SF_W (SF_W)
    ) u_exponent_calc (
        .max_abs (max_abs_reg),
        .exp_out (exp_next)
    );

    // rd_data_reg always holds the sample after the one being presented, so a
    // read is only issued when the output register advances.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            sample_mem[wr_idx_reg] <= in_data;
        end
        if (mem_re) begin
            rd_data_reg <= sample_mem[rd_idx_reg];
        end
    end

    always_comb begin
        q_ext = {rd_data_reg[IN_W-1], rd_data_reg};
        q_rnd = '0;
        if (ROUND_MODE == ROUND_HALF_UP && exp_reg != '0) begin
            q_rnd = (IN_W + 1)'(1) <<< (exp_reg - SF_W'(1));
        end
        q_shift = (q_ext + q_rnd) >>> exp_reg;
        if (q_shift > MAX_Q_EXT) begin
            q_sat = MAX_Q_Q;
        end else if (q_shift < -MAX_Q_EXT) begin
            q_sat = -MAX_Q_Q;
        end else begin
            q_sat = q_shift[Q_W-1:0];
        end
        q_word = OUT_W'(q_sat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= COLLECT;
            wr_idx_reg       <= '0;
            rd_idx_reg       <= '0;
            out_idx_reg      <= '0;
            max_abs_reg      <= '0;
            exp_reg          <= '0;
            in_ready_reg     <= 1'b0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            out_is_scale_reg <= 1'b0;
            out_last_reg     <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    in_ready_reg <= 1'b1;
                    if (in_fire) begin
                        if (abs_in > max_abs_reg) begin
                            max_abs_reg <= abs_in;
                        end
                        if (wr_idx_reg == LAST_IDX) begin
                            wr_idx_reg   <= '0;
                            in_ready_reg <= 1'b0;
                            state_reg    <= SCALE;
                        end else begin
                            wr_idx_reg <= wr_idx_reg + IDX_W'(1);
                        end
                    end
                end
                SCALE: begin
                    exp_reg          <= exp_next;
                    max_abs_reg      <= '0;
                    rd_idx_reg       <= rd_idx_reg + IDX_W'(1);
                    out_valid_reg    <= 1'b1;
                    out_data_reg     <= OUT_W'(exp_next);
                    out_is_scale_reg <= 1'b1;
                    out_last_reg     <= 1'b0;
                    state_reg        <= EMIT_SF;
                end
                EMIT_SF: begin
                    if (out_fire) begin
                        out_data_reg     <= q_word;
                        out_is_scale_reg <= 1'b0;
                        out_last_reg     <= (LAST_IDX == '0);
                        out_idx_reg      <= '0;
                        rd_idx_reg       <= rd_idx_reg + IDX_W'(1);
                        state_reg        <= EMIT_DATA;
                    end
                end
                EMIT_DATA: begin
                    if (out_fire) begin
                        if (out_idx_reg == LAST_IDX) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            out_idx_reg   <= '0;
                            rd_idx_reg    <= '0;
                            in_ready_reg  <= 1'b1;
                            state_reg     <= COLLECT;
                        end else begin
                            out_data_reg <= q_word;
                            out_idx_reg  <= out_idx_reg + IDX_W'(1);
                            out_last_reg <= ((out_idx_reg + IDX_W'(1)) == LAST_IDX);
                            rd_idx_reg   <= rd_idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end

endmodule

// File: doc/bfp_block_quantizer.md
Name: bfp_block_quantizer

Overview:
- Block-floating-point encoder on the compression datapath.
- Accepts a stream of signed input samples and collects them into blocks of BLOCK_SIZE.
- Finds each block's peak magnitude and derives a shared shift exponent.
- Emits one scaling word followed by BLOCK_SIZE quantized samples saturated to ±MAX_Q.
- Successor to the fixed 32/12/12/1024 configuration: widths, block size and rounding mode are parameters.

Parameters:
- IN_W, 32, input sample width (signed two's complement)
- SF_W, 12, scaling-word width (exponent, zero-extended)
- Q_W, 12, quantized sample width (signed)
- OUT_W, 32, output word width (≥ max(SF_W,Q_W))
- BLOCK_SIZE, 1024, samples per block (≥2)
- ROUND_MODE, 1, 0 = truncate (arithmetic shift), 1 = round half up before shift

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input
- in_data  in  IN_W  signed input sample
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  OUT_W  scaling word (zero-ext) or quantized sample (sign-ext)
- out_is_scale  out  1  current word is the scaling word
- out_last  out  1  current word is last sample of block

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - in_ready=0, out_valid=0, out_data=0, out_is_scale=0, out_last=0.
  - FSM=COLLECT, counters=0, max_abs=0.
  - in_ready rises the first cycle after rst deasserts.
- Handshakes: a transfer occurs when valid&&ready on a rising clk edge.
  - out_data, out_is_scale and out_last are registered.
  - They are held stable while out_valid && !out_ready.
  - out_valid, once high, stays high until the transfer.
- FSM states:
  - COLLECT: in_ready=1. Each accepted sample is written to the buffer at wr_idx, and max_abs=max(max_abs,|in_data|). |x| is computed unsigned on IN_W bits, so |-2^(IN_W-1)| = 2^(IN_W-1). On accept with wr_idx==BLOCK_SIZE-1, go to SCALE.
  - SCALE: one cycle, in_ready=0. Compute L = bit length of max_abs (0 for 0), then e = max(0, L-(Q_W-1)). Latch e and clear max_abs. Go to EMIT_SF.
  - EMIT_SF: present e zero-extended with out_is_scale=1. On transfer, go to EMIT_DATA.
  - EMIT_DATA: present q[i] for i=0..BLOCK_SIZE-1 in input order. out_last=1 for i==BLOCK_SIZE-1. Transfer of the last sample returns the FSM to COLLECT. Back-to-back transfers sustain 1 word/cycle when out_ready is held high.
- Quantization arithmetic:
  - ROUND_MODE=1: t=(x + 2^(e-1)) >>> e, evaluated on IN_W+1 bits so no overflow. If e=0, t=x.
  - ROUND_MODE=0: t = x >>> e.
  - q = clamp(t, -MAX_Q, +MAX_Q), with MAX_Q = 2^(Q_W-1)-1 (symmetric; -2^(Q_W-1) is never emitted).
- Latency: the first output word (scaling) is valid 2 cycles after the last input accept (SCALE, then registered output).
- Boundaries:
  - An all-zero block gives e=0 and all q=0.
  - A max-negative input gives e=IN_W-Q_W+1.
  - in_valid during SCALE/EMIT is ignored (in_ready=0), and no sample is lost.
  - rst at any point aborts the partial block: counters and max cleared, no partial output, out_valid drops asynchronously.
- Buffer: BLOCK_SIZE×IN_W single-port array. Synchronous read with 1-cycle latency is permitted; the output register/prefetch absorbs it under backpressure.

Decomposition:
- Shared package bfp_pkg holds:
  - default widths and BLOCK_SIZE
  - MAX_Q and MAX_SF derived functions
  - state enum typedef (COLLECT, SCALE, EMIT_SF, EMIT_DATA)
  - round-mode constants
- Sub-module bfp_exponent_calc: combinational leading-one detector plus e computation (max_abs→e). Reusable by the decoder.

Test Plan:
- The bench uses BLOCK_SIZE=4 and other parameters at defaults.
- Input [100,-50,2047,0] -> scale 0, then 100,-50,2047,0. out_last on the final word; the scale word has out_is_scale=1.
- ROUND_MODE=1 with input [4096,-4096,1,3] -> scale 2, then 1024,-1024,0,1. With ROUND_MODE=0 the same input gives 1024,-1024,0,0.
- Input [-2147483648,0,0,0] -> scale 21, then -1024,0,0,0.
- Saturation: input [8190,0,-8190,5] -> scale 2, then 2047,0,-2047,1 (8190 rounds to 2048 and is clamped).
- Backpressure: hold out_ready=0 for 5 cycles mid-EMIT_DATA -> out_data/out_valid stable. in_ready=0 throughout. No word duplicated or dropped after release.
- Assert rst after 2 samples of a block -> outputs at reset values immediately. A following full block encodes correctly, with the stale samples excluded from max_abs.
